bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- N-port round-robin arbiter between per-hart BUS masters and the single memory_controller port.
- Generalises the dual-hart arbitration to HARTS masters.
- Forwards atomic and operation sideband and the granted master ID.
- Holds a lock across an atomic read-modify-write sequence, so no other hart interleaves with it.

Parameters:
N_PORTS, 2, number of requesting masters (>=2)
IDW, $clog2(N_PORTS), width of o_id
LOCK_MAX, 16, lock-timeout cycle limit (used only with ARB_LOCK_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_bus_en  in  N_PORTS  per-master request, held until its ack
i_wr_en  in  N_PORTS  per-master write(1)/read(0)
i_wr_data  in  N_PORTS*32  flattened write data, port k at [32k+31:32k]
i_addr  in  N_PORTS*32  flattened address
i_byte_en  in  N_PORTS*4  flattened byte enables
i_atomic  in  N_PORTS  master is inside an atomic sequence
i_operation  in  N_PORTS*7  flattened funct7 of the atomic op
o_ack  out  N_PORTS  one-hot ack to the granted master
o_rd_data  out  N_PORTS*32  read data; granted slice = i_rd_data, others 0
o_bus_en  out  1  downstream request
o_wr_en, o_wr_data[32], o_addr[32], o_byte_en[4], o_atomic, o_operation[7]  out  muxed fields of the granted master
o_id  out  IDW  index of the granted master
i_ack  in  1  downstream ack, 1-cycle pulse
i_rd_data  in  32  downstream read data, valid with i_ack
o_lock_timeout  out  1  lock-timeout pulse

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - state=IDLE, grant=0, ptr=0.
  - All outputs 0.
  - Applies mid-transaction too: any outstanding transaction is dropped with no ack.
- States: IDLE, BUSY, LOCKED.
- IDLE:
  - If any i_bus_en is high, grant = first requester at or above ptr (circular search). The grant register loads on the clock edge and state goes to BUSY.
  - Request at cycle t gives o_bus_en=1 at t+1.
- BUSY:
  - o_bus_en = i_bus_en[grant].
  - All downstream fields are muxed combinationally from the grant slice. o_id = grant.
  - o_ack[grant] = i_ack in the same cycle; o_rd_data slice likewise.
- On i_ack in BUSY:
  - ptr = (grant+1) mod N_PORTS, with wrap-around at N_PORTS-1 to 0.
  - If i_atomic[grant]=1, go to LOCKED; else go to IDLE.
- If i_bus_en[grant] drops in BUSY without i_ack (protocol violation), go to IDLE and leave ptr unchanged.
- LOCKED:
  - o_bus_en=0. Only the grant master is eligible; other masters' requests are ignored and wait.
  - i_bus_en[grant]=1 goes to BUSY with the same grant.
  - i_atomic[grant]=0 and i_bus_en[grant]=0 goes to IDLE.
- Simultaneous events:
  - i_ack and a new request arrive together: the ack completes first. The new request is arbitrated in IDLE next cycle, giving 1 idle bubble.
  - A request from the just-acked master is lowest priority on the next pick.
- Throughput: at most one transaction per 2 cycles plus downstream latency.
- o_lock_timeout is 0 except as given under Optional Feature.

Optional Feature:
ARB_LOCK_TIMEOUT_EN
- Defined:
  - A counter clears on entering LOCKED and increments each LOCKED cycle with no grant request.
  - At count == LOCK_MAX-1: force IDLE, set ptr = grant+1, pulse o_lock_timeout for 1 cycle.
- Undefined: no counter; the lock holds indefinitely; o_lock_timeout is tied 0.

Decomposition:
- Shared package:
  - state encoding (IDLE, BUSY, LOCKED);
  - bus field widths: XLEN=32, BE_W=4, OP_W=7;
  - AMO funct7 constants, already used by memory_controller.
- One sub-module, rr_pick:
  - combinational circular first-one search;
  - inputs: request vector, ptr; outputs: index, valid.
  - Reusable by other schedulers.

Test Plan:
- Single request: N=2, only port1 requests a read of addr 0x100, i_ack 3 cycles later with rd_data 0xDEADBEEF -> o_bus_en=1 one cycle after request, o_id=1, o_ack=2'b10, o_rd_data[63:32]=0xDEADBEEF, then IDLE.
- Contention fairness: N=4, all four request continuously, ack after 1 cycle -> grant order 0,1,2,3,0 with no starvation; each o_ack one-hot.
- Atomic lock: port0 atomic=1 performs read then write (AMOADD, op 7'b0000000) while port1 requests -> port1 gets no o_bus_en until port0 drops atomic; then port1 is granted.
- Wrap and simultaneity: ptr=N-1 with ports N-1 and 0 requesting -> N-1 served first, then 0. A new request arriving in the ack cycle is served after exactly one bubble.
- Reset mid-op: assert i_rst_n=0 asynchronously during BUSY -> all outputs 0 immediately, no o_ack. After release, a new request gets grant from port 0.
- Timeout (ARB_LOCK_TIMEOUT_EN, LOCK_MAX=16): port0 locks then goes idle -> o_lock_timeout pulses after 16 LOCKED cycles and port1 is granted next.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding,
// bus field widths and the AMO funct7 codes also used by memory_controller.
package bus_arbiter_rr_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = 4;
   localparam int OP_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_LOCKED = 2'd2
   } arb_state_e;

   // funct7 with aq/rl cleared
   localparam logic [OP_W-1:0] AMO_ADD  = 7'b0000000;
   localparam logic [OP_W-1:0] AMO_SWAP = 7'b0000100;
   localparam logic [OP_W-1:0] AMO_LR   = 7'b0001000;
   localparam logic [OP_W-1:0] AMO_SC   = 7'b0001100;
   localparam logic [OP_W-1:0] AMO_XOR  = 7'b0010000;
   localparam logic [OP_W-1:0] AMO_OR   = 7'b0100000;
   localparam logic [OP_W-1:0] AMO_AND  = 7'b0110000;
   localparam logic [OP_W-1:0] AMO_MIN  = 7'b1000000;
   localparam logic [OP_W-1:0] AMO_MAX  = 7'b1010000;
   localparam logic [OP_W-1:0] AMO_MINU = 7'b1100000;
   localparam logic [OP_W-1:0] AMO_MAXU = 7'b1110000;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational circular first-one search: returns the first set request
// at or above i_ptr, wrapping from N_PORTS-1 back to 0.
module bus_arbiter_rr_pick #(
   parameter int N_PORTS = 2,
   parameter int IDW     = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [IDW-1:0]     o_idx,
   output logic               o_valid
);

   localparam logic [IDW-1:0] LAST_IDX = IDW'(N_PORTS - 1);

   logic [IDW-1:0] scan;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      scan    = i_ptr;
      for (int i = 0; i < N_PORTS; i++) begin
         if (!o_valid && i_req[scan]) begin
            o_valid = 1'b1;
            o_idx   = scan;
         end
         scan = (scan == LAST_IDX) ? '0 : scan + IDW'(1);
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-port round-robin arbiter in front of the memory_controller port, with a
// lock held across atomic sequences. Optional lock timeout: ARB_LOCK_TIMEOUT_EN.
module bus_arbiter_rr
   import bus_arbiter_rr_pkg::*;
#(
   parameter int N_PORTS  = 2,
   parameter int IDW      = $clog2(N_PORTS),
   parameter int LOCK_MAX = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_PORTS-1:0]      i_bus_en,
   input  logic [N_PORTS-1:0]      i_wr_en,
   input  logic [N_PORTS*XLEN-1:0] i_wr_data,
   input  logic [N_PORTS*XLEN-1:0] i_addr,
   input  logic [N_PORTS*BE_W-1:0] i_byte_en,
   input  logic [N_PORTS-1:0]      i_atomic,
   input  logic [N_PORTS*OP_W-1:0] i_operation,
   output logic [N_PORTS-1:0]      o_ack,
   output logic [N_PORTS*XLEN-1:0] o_rd_data,
   output logic                    o_bus_en,
   output logic                    o_wr_en,
   output logic [XLEN-1:0]         o_wr_data,
   output logic [XLEN-1:0]         o_addr,
   output logic [BE_W-1:0]         o_byte_en,
   output logic                    o_atomic,
   output logic [OP_W-1:0]         o_operation,
   output logic [IDW-1:0]          o_id,
   input  logic                    i_ack,
   input  logic [XLEN-1:0]         i_rd_data,
   output logic                    o_lock_timeout,
   output logic [1:0]              o_state
);

   // Handshake: a master holds i_bus_en (and its fields) until it sees its
   // o_ack bit; downstream sees o_bus_en until the one-cycle i_ack pulse.

   if (N_PORTS < 2 || LOCK_MAX < 2) begin : g_param_check
      $error("bus_arbiter_rr: N_PORTS and LOCK_MAX must both be >= 2");
   end

   localparam logic [IDW-1:0] LAST_IDX = IDW'(N_PORTS - 1);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] pick_idx;
   logic [IDW-1:0] grant_inc;
   logic           pick_valid;
   logic           busy;
   logic           lock_timeout;

   logic [XLEN-1:0] wr_data_a   [N_PORTS];
   logic [XLEN-1:0] addr_a      [N_PORTS];
   logic [BE_W-1:0] byte_en_a   [N_PORTS];
   logic [OP_W-1:0] operation_a [N_PORTS];

   bus_arbiter_rr_pick #(
      .N_PORTS (N_PORTS),
      .IDW     (IDW)
   ) u_pick (
      .i_req   (i_bus_en),
      .i_ptr   (ptr_q),
      .o_idx   (pick_idx),
      .o_valid (pick_valid)
   );

   assign busy      = (state_q == ST_BUSY);
   assign grant_inc = (grant_q == LAST_IDX) ? '0 : grant_q + IDW'(1);

`ifdef ARB_LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(LOCK_MAX);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

   logic [CNT_W-1:0] lock_cnt_q;

   // Counts idle cycles spent holding the lock; zero on the first LOCKED cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lock_cnt_q <= '0;
      end else if (state_q != ST_LOCKED) begin
         lock_cnt_q <= '0;
      end else if (!i_bus_en[grant_q]) begin
         lock_cnt_q <= lock_cnt_q + CNT_W'(1);
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      ptr_d        = ptr_q;
      lock_timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // The ack wins over a dropped request in the same cycle.
            if (i_ack) begin
               ptr_d   = grant_inc;
               state_d = i_atomic[grant_q] ? ST_LOCKED : ST_IDLE;
            end else if (!i_bus_en[grant_q]) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (i_bus_en[grant_q]) begin
               state_d = ST_BUSY;
            end else if (!i_atomic[grant_q]) begin
               state_d = ST_IDLE;
            end
`ifdef ARB_LOCK_TIMEOUT_EN
            else if (lock_cnt_q == LOCK_LAST) begin
               state_d      = ST_IDLE;
               ptr_d        = grant_inc;
               lock_timeout = 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar k = 0; k < N_PORTS; k++) begin : g_port
      assign wr_data_a[k]   = i_wr_data[k*XLEN +: XLEN];
      assign addr_a[k]      = i_addr[k*XLEN +: XLEN];
      assign byte_en_a[k]   = i_byte_en[k*BE_W +: BE_W];
      assign operation_a[k] = i_operation[k*OP_W +: OP_W];
      assign o_ack[k]       = busy && (grant_q == IDW'(k)) && i_ack;
      assign o_rd_data[k*XLEN +: XLEN] = (busy && (grant_q == IDW'(k))) ? i_rd_data : '0;
   end

   // Downstream fields are zero outside BUSY so reset and idle present a clean bus.
   assign o_bus_en       = busy & i_bus_en[grant_q];
   assign o_wr_en        = busy & i_wr_en[grant_q];
   assign o_wr_data      = busy ? wr_data_a[grant_q]   : '0;
   assign o_addr         = busy ? addr_a[grant_q]      : '0;
   assign o_byte_en      = busy ? byte_en_a[grant_q]   : '0;
   assign o_atomic       = busy & i_atomic[grant_q];
   assign o_operation    = busy ? operation_a[grant_q] : '0;
   assign o_id           = busy ? grant_q : '0;
   assign o_lock_timeout = lock_timeout;
   assign o_state        = state_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized scoreboard bench for bus_arbiter_rr (4 ports) against a
// transaction-level reference model of the round-robin and lock rules.
module tb_bus_arbiter_rr;
   import bus_arbiter_rr_pkg::*;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TW  = IDW + 1 + 32 + 32 + 4 + 1 + 7;
   localparam int AW  = N + N * 32;

   logic            clk, rst_n;
   logic [N-1:0]    bus_en, wr_en, atomic;
   logic [N*32-1:0] wr_data, addr;
   logic [N*4-1:0]  byte_en;
   logic [N*7-1:0]  operation;
   logic            ack_in;
   logic [31:0]     rd_data_in;

   logic [N-1:0]    out_ack;
   logic [N*32-1:0] out_rd_data;
   logic            out_bus_en, out_wr_en, out_atomic, out_lock_timeout;
   logic [31:0]     out_wr_data, out_addr;
   logic [3:0]      out_byte_en;
   logic [6:0]      out_operation;
   logic [IDW-1:0]  out_id;
   logic [1:0]      out_state;

   logic [TW-1:0]   dut_txn;
   logic [AW-1:0]   dut_ackv;
   logic [214:0]    all_out;

   assign dut_txn  = {out_id, out_wr_en, out_wr_data, out_addr, out_byte_en, out_atomic, out_operation};
   assign dut_ackv = {out_ack, out_rd_data};
   assign all_out  = {out_ack, out_rd_data, out_bus_en, out_wr_en, out_wr_data, out_addr,
                      out_byte_en, out_atomic, out_operation, out_id, out_lock_timeout, out_state};

   bus_arbiter_rr #(.N_PORTS(N), .IDW(IDW), .LOCK_MAX(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_bus_en(bus_en), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_addr(addr),
      .i_byte_en(byte_en), .i_atomic(atomic), .i_operation(operation),
      .o_ack(out_ack), .o_rd_data(out_rd_data), .o_bus_en(out_bus_en),
      .o_wr_en(out_wr_en), .o_wr_data(out_wr_data), .o_addr(out_addr),
      .o_byte_en(out_byte_en), .o_atomic(out_atomic), .o_operation(out_operation),
      .o_id(out_id), .i_ack(ack_in), .i_rd_data(rd_data_in),
      .o_lock_timeout(out_lock_timeout), .o_state(out_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   bit mon_en     = 0;
   bit prev_bus   = 0;

   logic [TW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [AW-1:0] ack_q[$];
   int            ack_cyc_q[$];

   // Reference model: who owns the bus, whether a lock is held, next priority.
   bit m_busy, m_locked;
   int m_owner, m_ptr, m_lat;

   // Master / responder control
   bit         acked[N];
   int         ops_left[N];
   int         hold[N];
   logic [N-1:0] auto_mask;
   bit         rand_en;
   int         lat_fixed;
   bit         rd_fixed_en;
   logic [31:0] rd_fixed;
   logic [6:0] amo_ops[4];

   function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("bus_en_timeout", {out_bus_en, out_lock_timeout}, {m_busy, 1'b0});
            if (out_bus_en && !prev_bus) begin
               if (exp_q.size() == 0) begin
                  compared++; mismatched++;
                  $display("FAIL grant_unexpected @cyc %0d: got id %0d expected no grant", cyc, out_id);
               end else begin
                  check("grant_fields", dut_txn, exp_q.pop_front());
                  check("grant_cycle", cyc, exp_cyc_q.pop_front());
               end
            end
            if (ack_in || out_ack != '0) begin
               if (ack_q.size() == 0) begin
                  compared++; mismatched++;
                  $display("FAIL ack_unexpected @cyc %0d: got ack %0b expected none", cyc, out_ack);
               end else begin
                  check("ack_rdata", dut_ackv, ack_q.pop_front());
                  check("ack_cycle", cyc, ack_cyc_q.pop_front());
               end
            end
         end
         prev_bus = out_bus_en;
      end
   end

   // ---------------- reference model ----------------
   task automatic grant_to(input int k);
      m_owner  = k;
      m_busy   = 1;
      m_locked = 0;
      m_lat    = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
      exp_q.push_back({IDW'(k), wr_en[k], wr_data[k*32 +: 32], addr[k*32 +: 32],
                       byte_en[k*4 +: 4], atomic[k], operation[k*7 +: 7]});
      exp_cyc_q.push_back(cyc);
   endtask

   task automatic model_update();
      bit found;
      if (m_busy) begin
         if (ack_in) begin
            m_busy        = 0;
            m_ptr         = (m_owner + 1) % N;
            m_locked      = atomic[m_owner];
            acked[m_owner] = 1;
         end else if (!bus_en[m_owner]) begin
            m_busy = 0;
         end
      end else if (m_locked) begin
         if (bus_en[m_owner]) grant_to(m_owner);
         else if (!atomic[m_owner]) m_locked = 0;
      end else begin
         found = 0;
         for (int i = 0; i < N; i++) begin
            if (!found && bus_en[(m_ptr + i) % N]) begin
               found = 1;
               grant_to((m_ptr + i) % N);
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int k, input logic wr, input logic [31:0] a, input logic at, input logic [6:0] op);
      bus_en[k]           = 1'b1;
      wr_en[k]            = wr;
      atomic[k]           = at;
      addr[k*32 +: 32]    = a;
      wr_data[k*32 +: 32] = $urandom;
      byte_en[k*4 +: 4]   = 4'($urandom_range(1, 15));
      operation[k*7 +: 7] = op;
      ops_left[k]         = at ? 2 : 1;
      hold[k]             = 0;
   endtask

   task automatic start_req(input int k, input bit at);
      logic [6:0] op;
      logic       wr;
      op = at ? amo_ops[$urandom_range(0, 3)] : 7'($urandom_range(0, 127));
      wr = at ? 1'b0 : 1'($urandom_range(0, 1));
      set_req(k, wr, $urandom & 32'hFFFF_FFFC, at, op);
   endtask

   task automatic drive_next();
      logic [N*32-1:0] rdv;
      for (int k = 0; k < N; k++) begin
         if (acked[k]) begin
            acked[k]  = 0;
            bus_en[k] = 1'b0;
            ops_left[k]--;
            if (ops_left[k] > 0) begin
               bus_en[k]           = 1'b1;
               wr_en[k]            = 1'b1;
               wr_data[k*32 +: 32] = $urandom;
            end else if (atomic[k]) begin
               hold[k] = $urandom_range(0, 2);
            end
         end
      end
      for (int k = 0; k < N; k++) begin
         if (bus_en[k]) continue;
         if (atomic[k]) begin
            if (hold[k] > 0) hold[k]--;
            else atomic[k] = 1'b0;
            continue;
         end
         if (auto_mask[k] || (rand_en && $urandom_range(0, 2) == 0))
            start_req(k, rand_en && $urandom_range(0, 4) == 0);
      end
      ack_in = 1'b0;
      if (m_busy) begin
         if (m_lat == 0) begin
            ack_in     = 1'b1;
            rd_data_in = rd_fixed_en ? rd_fixed : $urandom;
            rdv        = '0;
            rdv[m_owner*32 +: 32] = rd_data_in;
            ack_q.push_back({N'(1) << m_owner, rdv});
            ack_cyc_q.push_back(cyc);
         end else begin
            m_lat--;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_update();
      #1;
      drive_next();
   endtask

   task automatic clear_inputs();
      bus_en = '0; wr_en = '0; atomic = '0; wr_data = '0; addr = '0;
      byte_en = '0; operation = '0; ack_in = 1'b0; rd_data_in = '0;
      for (int k = 0; k < N; k++) begin
         acked[k] = 0; ops_left[k] = 0; hold[k] = 0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((m_busy || m_locked || bus_en != '0 || atomic != '0) && n < 200) begin
         step();
         n++;
      end
      check("drain_within_bound", 256'(n < 200), 256'(1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      amo_ops[0] = AMO_ADD; amo_ops[1] = AMO_SWAP; amo_ops[2] = AMO_OR; amo_ops[3] = AMO_MAXU;
      rand_en = 0; auto_mask = '0; lat_fixed = -1; rd_fixed_en = 0; rd_fixed = '0;
      m_busy = 0; m_locked = 0; m_owner = 0; m_ptr = 0; m_lat = 0;
      clear_inputs();

      // Reset with busy-looking inputs: every output must still read zero.
      rst_n = 1'b0;
      bus_en = '1; atomic = '1; wr_en = '1; addr = {4{32'h1234_5678}};
      operation = '1; ack_in = 1'b1; rd_data_in = 32'hFFFF_FFFF;
      #22;
      check("reset_outputs", 256'(all_out), 256'(0));
      clear_inputs();
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      mon_en = 1;
      step();

      // Single read from port 1, ack three cycles after the request.
      lat_fixed = 2; rd_fixed_en = 1; rd_fixed = 32'hDEAD_BEEF;
      set_req(1, 1'b0, 32'h0000_0100, 1'b0, 7'h00);
      drain();
      rd_fixed_en = 0;

      // Contention: all four request continuously, ack in the first busy cycle.
      lat_fixed = 0; auto_mask = '1;
      repeat (30) step();
      auto_mask = '0;
      drain();

      // Atomic read+write on port 0 while port 1 waits.
      lat_fixed = 1;
      set_req(0, 1'b0, 32'h0000_0200, 1'b1, AMO_ADD);
      step();
      set_req(1, 1'b1, 32'h0000_0300, 1'b0, 7'h00);
      drain();

      // Wrap: move priority to port 3, then ports 3 and 0 request together.
      set_req(2, 1'b0, 32'h0000_0400, 1'b0, 7'h00);
      drain();
      set_req(3, 1'b1, 32'h0000_0500, 1'b0, 7'h00);
      set_req(0, 1'b0, 32'h0000_0600, 1'b0, 7'h00);
      drain();

      // Reset in the middle of a transaction.
      lat_fixed = 6;
      set_req(2, 1'b1, 32'h0000_0700, 1'b0, 7'h00);
      step(); step(); step();
      mon_en = 0;
      ack_in = 1'b1; rd_data_in = 32'hA5A5_A5A5;
      #3 rst_n = 1'b0;
      #1 check("reset_mid_op", 256'(all_out), 256'(0));
      clear_inputs();
      exp_q.delete(); exp_cyc_q.delete(); ack_q.delete(); ack_cyc_q.delete();
      m_busy = 0; m_locked = 0; m_ptr = 0;
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      mon_en = 1;
      lat_fixed = 1;
      set_req(3, 1'b0, 32'h0000_0800, 1'b0, 7'h00);
      set_req(0, 1'b0, 32'h0000_0900, 1'b0, 7'h00);
      drain();

      // Random traffic including atomic sequences.
      lat_fixed = -1; rand_en = 1;
      repeat (1500) step();
      rand_en = 0;
      drain();
      repeat (3) step();

      check("grants_outstanding", 256'(exp_q.size()), 256'(0));
      check("acks_outstanding", 256'(ack_q.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
